serial_lut_loader: RTL and testbench

//   Transmit side of the serial LUT-load interface. Accepts a full LUT table as one

---
 rtl/serial_lut_loader.sv | 145 ++++++++++++++
 tb/tb_serial_lut_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_lut_loader.sv
// serial_lut_loader: shifts a whole LUT table out MSB-first on sclk/sd,
// framed by an active-low scs_n, for a serial-load LUT receiver that samples
// sd on every sclk rising edge while scs_n is low.
//
// Handshake: start_ready is high exactly when the block is idle. A transfer
// is accepted on the posedge where start_valid && start_ready && !abort. At
// that edge table_in is copied into the shadow register and then ignored.
// start_valid while busy is dropped, not queued. start_ready returns high in
// the done cycle, so a new request can be accepted on the edge that ends it.
module serial_lut_loader #(
  parameter int IN_WIDTH    = 4,
  parameter int OUT_WIDTH   = 4,
  parameter int HALF_PERIOD = 2,
  localparam int TABLE_BITS = (2 ** IN_WIDTH) * OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TABLE_BITS-1:0] table_in,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  abort,
  output logic                  sclk,
  output logic                  sd,
  output logic                  scs_n,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam int HP_W  = $clog2(HALF_PERIOD + 1);
  localparam int BIT_W = $clog2(TABLE_BITS + 1);
  // Each timed phase counts down from HALF_PERIOD-1 to 0.
  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                  state_q;
  logic [TABLE_BITS-1:0]   shadow_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [HP_W-1:0]         hp_cnt_q;

  assign state_dbg = state_q;

  // Frame sequencer: state, counters, shadow register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      hp_cnt_q    <= '0;
      scs_n       <= 1'b1;
      sclk        <= 1'b0;
      sd          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        // Abort drops the frame on this edge with no done pulse.
        state_q     <= S_IDLE;
        bit_cnt_q   <= '0;
        hp_cnt_q    <= '0;
        scs_n       <= 1'b1;
        sclk        <= 1'b0;
        sd          <= 1'b0;
        busy        <= 1'b0;
        start_ready <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_valid && start_ready && !abort) begin
              shadow_q    <= table_in;
              bit_cnt_q   <= BIT_W'(TABLE_BITS);
              hp_cnt_q    <= HP_LOAD;
              state_q     <= S_SETUP;
              scs_n       <= 1'b0;
              sclk        <= 1'b0;
              sd          <= table_in[TABLE_BITS-1];
              busy        <= 1'b1;
              start_ready <= 1'b0;
            end
          end
          S_SETUP: begin
            if (hp_cnt_q == '0) begin
              state_q  <= S_HIGH;
              sclk     <= 1'b1;
              hp_cnt_q <= HP_LOAD;
            end else begin
              hp_cnt_q <= hp_cnt_q - 1'b1;
            end
          end
          S_HIGH: begin
            if (hp_cnt_q == '0) begin
              // The receiver has sampled this bit; advance to the next one.
              shadow_q  <= {shadow_q[TABLE_BITS-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 1'b1;
              sclk      <= 1'b0;
              hp_cnt_q  <= HP_LOAD;
              if (bit_cnt_q == BIT_W'(1)) begin
                state_q <= S_HOLD;
              end else begin
                state_q <= S_LOW;
                sd      <= shadow_q[TABLE_BITS-2];
              end
            end else begin
              hp_cnt_q <= hp_cnt_q - 1'b1;
            end
          end
          S_LOW: begin
            if (hp_cnt_q == '0) begin
              state_q  <= S_HIGH;
              sclk     <= 1'b1;
              hp_cnt_q <= HP_LOAD;
            end else begin
              hp_cnt_q <= hp_cnt_q - 1'b1;
            end
          end
          S_HOLD: begin
            if (hp_cnt_q == '0) begin
              state_q     <= S_IDLE;
              scs_n       <= 1'b1;
              sd          <= 1'b0;
              busy        <= 1'b0;
              start_ready <= 1'b1;
              done        <= 1'b1;
            end else begin
              hp_cnt_q <= hp_cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_lut_loader.sv
// Bench for serial_lut_loader: a default instance (HALF_PERIOD=2) and a fast
// instance (HALF_PERIOD=1), both observed by a behavioural serial receiver.
module tb_serial_lut_loader;

  localparam int TB   = 64;
  localparam int HP_A = 2;
  localparam int HP_B = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [TB-1:0] a_table_in, b_table_in;
  logic a_start_valid, a_abort, b_start_valid, b_abort;
  logic a_start_ready, a_sclk, a_sd, a_scs_n, a_busy, a_done;
  logic b_start_ready, b_sclk, b_sd, b_scs_n, b_busy, b_done;
  logic [2:0] a_state_dbg, b_state_dbg;

  serial_lut_loader #(.IN_WIDTH(4), .OUT_WIDTH(4), .HALF_PERIOD(HP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .table_in(a_table_in), .start_valid(a_start_valid),
    .start_ready(a_start_ready), .abort(a_abort), .sclk(a_sclk), .sd(a_sd),
    .scs_n(a_scs_n), .busy(a_busy), .done(a_done), .state_dbg(a_state_dbg)
  );

  serial_lut_loader #(.IN_WIDTH(4), .OUT_WIDTH(4), .HALF_PERIOD(HP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .table_in(b_table_in), .start_valid(b_start_valid),
    .start_ready(b_start_ready), .abort(b_abort), .sclk(b_sclk), .sd(b_sd),
    .scs_n(b_scs_n), .busy(b_busy), .done(b_done), .state_dbg(b_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [TB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- receiver model results ----------------
  int rise_q[$];
  int done_cyc[$];
  logic [TB-1:0] rx_word;

  // Drive one request into dut_a and observe it like a serial receiver.
  // kill: 0 = run to completion, 1 = abort after kill_n rises, 2 = reset in cycle kill_n.
  task automatic run_a(input string name, input logic [TB-1:0] tbl, input bit hold_valid,
                       input logic [TB-1:0] alt, input int kill, input int kill_n);
    int cyc, limit, bad, exp_done, exp_r;
    bit prev_sclk, killed;
    logic sd_h[1024];
    logic [TB-1:0] exp_tbl;
    rise_q.delete();
    done_cyc.delete();
    rx_word   = '0;
    exp_done  = 1 + HP_A * (2 * TB + 1);
    limit     = exp_done + 4;
    cyc       = 0;
    prev_sclk = 1'b0;
    killed    = 1'b0;
    if (kill == 0) exp_q.push_back(tbl);
    a_table_in    = tbl;
    a_start_valid = 1'b1;
    while (cyc < limit) begin
      step();
      cyc++;
      if (cyc == 1) begin
        if (hold_valid) a_table_in = alt;
        else begin
          a_start_valid = 1'b0;
          a_table_in    = {$urandom, $urandom};
        end
        check($sformatf("%s.scs_fall", name), a_scs_n, 0);
        check($sformatf("%s.busy_on", name), a_busy, 1);
        check($sformatf("%s.ready_off", name), a_start_ready, 0);
      end
      sd_h[cyc] = a_sd;
      if (a_sclk && !prev_sclk && !a_scs_n) begin
        rise_q.push_back(cyc);
        rx_word = {rx_word[TB-2:0], a_sd};
      end
      prev_sclk = a_sclk;
      if (a_done) begin
        done_cyc.push_back(cyc);
        a_start_valid = 1'b0;
        check($sformatf("%s.done_ready", name), a_start_ready, 1);
        check($sformatf("%s.done_idle", name), {a_busy, a_scs_n, a_sclk}, 3'b010);
      end
      if (!killed && kill == 1 && rise_q.size() == kill_n) begin
        killed = 1'b1;
        a_abort = 1'b1;
        step();
        cyc++;
        a_abort = 1'b0;
        a_start_valid = 1'b0;
        check($sformatf("%s.abort_idle", name), {a_scs_n, a_sclk, a_busy, a_start_ready, a_done}, 5'b10010);
        prev_sclk = a_sclk;
        sd_h[cyc] = a_sd;
        limit = cyc + 6;
      end
      if (!killed && kill == 2 && cyc == kill_n) begin
        killed = 1'b1;
        rst_n = 1'b0;
        step();
        cyc++;
        rst_n = 1'b1;
        a_start_valid = 1'b0;
        check($sformatf("%s.reset_idle", name),
              {a_scs_n, a_sclk, a_sd, a_busy, a_start_ready, a_done}, 6'b100010);
        prev_sclk = a_sclk;
        sd_h[cyc] = a_sd;
        limit = cyc + 6;
      end
    end
    if (kill == 0) begin
      check($sformatf("%s.rise_count", name), rise_q.size(), TB);
      bad = 0;
      foreach (rise_q[k]) if (rise_q[k] != 1 + HP_A * (1 + 2 * k)) bad++;
      check($sformatf("%s.rise_times", name), bad, 0);
      check($sformatf("%s.done_count", name), done_cyc.size(), 1);
      check($sformatf("%s.done_cycle", name), (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
      bad = 0;
      foreach (rise_q[k])
        for (int j = rise_q[k] - HP_A; j < rise_q[k] + HP_A; j++)
          if (sd_h[j] !== sd_h[rise_q[k]]) bad++;
      check($sformatf("%s.sd_stable", name), bad, 0);
      exp_tbl = exp_q.pop_front();
      check($sformatf("%s.rx_word", name), rx_word, exp_tbl);
    end else begin
      check($sformatf("%s.no_done", name), done_cyc.size(), 0);
      if (kill == 1) begin
        exp_r = kill_n;
      end else begin
        exp_r = 0;
        for (int k = 0; k < TB; k++) if (1 + HP_A * (1 + 2 * k) <= kill_n) exp_r++;
      end
      check($sformatf("%s.partial_rises", name), rise_q.size(), exp_r);
      check($sformatf("%s.partial_rx", name), rx_word, tbl >> (TB - exp_r));
    end
  endtask

  // dut_b: start_valid stays high through the done cycle, so two frames run back to back.
  task automatic run_b();
    int cyc, bad, exp_r;
    bit prev_sclk;
    int rises[$];
    int dones[$];
    logic [TB-1:0] t1, t2, rx1, rx2;
    t1 = {$urandom, $urandom};
    t2 = {$urandom, $urandom};
    rx1 = '0;
    rx2 = '0;
    cyc = 0;
    prev_sclk = 1'b0;
    b_table_in = t1;
    b_start_valid = 1'b1;
    while (cyc < 266) begin
      step();
      cyc++;
      if (cyc == 1) b_table_in = t2;
      if (b_sclk && !prev_sclk && !b_scs_n) begin
        rises.push_back(cyc);
        if (rises.size() <= TB) rx1 = {rx1[TB-2:0], b_sd};
        else rx2 = {rx2[TB-2:0], b_sd};
      end
      prev_sclk = b_sclk;
      if (b_done) begin
        dones.push_back(cyc);
        check("b2b.done_ready", b_start_ready, 1);
      end
      if (cyc == 131) begin
        check("b2b.second_scs_fall", b_scs_n, 0);
        check("b2b.second_busy", b_busy, 1);
        b_start_valid = 1'b0;
      end
    end
    check("b2b.rise_count", rises.size(), 2 * TB);
    bad = 0;
    foreach (rises[k]) begin
      exp_r = (k < TB) ? 2 + 2 * k : 130 + 2 + 2 * (k - TB);
      if (rises[k] != exp_r) bad++;
    end
    check("b2b.rise_times", bad, 0);
    check("b2b.done_count", dones.size(), 2);
    check("b2b.done0", (dones.size() > 0) ? dones[0] : -1, 130);
    check("b2b.done1", (dones.size() > 1) ? dones[1] : -1, 260);
    check("b2b.rx1", rx1, t1);
    check("b2b.rx2", rx2, t2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [TB-1:0] t, alt;
    rst_n = 1'b0;
    a_table_in = '0; a_start_valid = 1'b0; a_abort = 1'b0;
    b_table_in = '0; b_start_valid = 1'b0; b_abort = 1'b0;
    repeat (3) step();
    check("reset.a_outputs", {a_scs_n, a_sclk, a_sd, a_busy, a_done, a_start_ready}, 6'b100001);
    check("reset.b_outputs", {b_scs_n, b_sclk, b_sd, b_busy, b_done, b_start_ready}, 6'b100001);
    rst_n = 1'b1;
    step();

    // Known table; receiver lookup of sel returns sel.
    run_a("known", 64'hFEDCBA9876543210, 1'b0, '0, 0, 0);
    for (int sel = 0; sel < 16; sel++)
      check($sformatf("known.lookup%0d", sel), rx_word[sel*4 +: 4], sel);

    // start_valid held with a different table through the frame.
    run_a("held", {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 0, 0);

    // Abort after the 10th rise, then a fresh frame.
    run_a("abort10", {$urandom, $urandom}, 1'b0, '0, 1, 10);
    run_a("after_abort", {$urandom, $urandom}, 1'b0, '0, 0, 0);

    // Reset in cycle 100 of a frame.
    run_a("reset100", {$urandom, $urandom}, 1'b0, '0, 2, 100);

    // Abort in IDLE wins over start_valid.
    a_table_in = {$urandom, $urandom};
    a_start_valid = 1'b1;
    a_abort = 1'b1;
    step();
    check("idle_abort.blocked", {a_busy, a_scs_n, a_start_ready}, 3'b011);
    a_abort = 1'b0;
    a_start_valid = 1'b0;
    step();
    check("idle_abort.still_idle", a_busy, 0);

    // Randomized frames, some with held start_valid, one random abort point.
    for (int f = 0; f < 3; f++) begin
      t = {$urandom, $urandom};
      alt = {$urandom, $urandom};
      run_a($sformatf("rand%0d", f), t, 1'($urandom_range(0, 1)), alt, 0, 0);
    end
    run_a("rand_abort", {$urandom, $urandom}, 1'b0, '0, 1, $urandom_range(1, TB - 1));
    run_a("rand_last", {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 0, 0);

    // HALF_PERIOD=1 back-to-back frames.
    run_b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
